// File: rtl/mem_bus_master_if.sv
// Purpose : CPU request/response and bus strobe/address signals of mem_bus_master.
//           The tri-state byte lane stays a plain inout port on the master.
// Ports   : master = mem_bus_master view, slave = CPU core + memory responder view.
interface mem_bus_master_if;
  // CPU side
  logic        start;
  logic        is_write;
  logic        is_word;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  // Memory bus side
  logic        req_read;
  logic        req_write;
  logic [15:0] addr_bus;

  modport master (
    input  start, is_write, is_word, addr, wdata,
    output busy, done, rdata, req_read, req_write, addr_bus
  );

  modport slave (
    output start, is_write, is_word, addr, wdata,
    input  busy, done, rdata, req_read, req_write, addr_bus
  );
endinterface

// File: rtl/mem_bus_master.sv
// Purpose : turns a single-cycle CPU byte/word request into one or two little-endian byte bus cycles.
// Latency : byte done at T+W+2, word done at T+2W+3 (W = WAIT_STATES, start accepted at edge T).
// Backpr. : no queueing; start is only accepted in IDLE and ignored while busy or done.
// Ports   : clk, reset (sync, active-low), bus (mem_bus_master_if.master: CPU request/response,
//           req_read/req_write/addr_bus), data_bus (8-bit tri-state lane, driven only while req_write=1).
module mem_bus_master #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_bus_master_if.master         bus,
  inout  wire  [7:0]               data_bus
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        is_write_q;
  logic        is_word_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] rdata_q;
  logic        req_read_q;
  logic        req_write_q;
  logic [15:0] addr_bus_q;
  logic [7:0]  dout_q;

  // All outputs are registered; each state's bus values are loaded on the edge
  // that enters it so they are stable for the whole bus cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      is_write_q  <= 1'b0;
      is_word_q   <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 16'h0000;
      req_read_q  <= 1'b0;
      req_write_q <= 1'b0;
      addr_bus_q  <= 16'h0000;
      dout_q      <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            is_write_q  <= bus.is_write;
            is_word_q   <= bus.is_word;
            addr_q      <= bus.addr;
            wdata_q     <= bus.wdata;
            cnt_q       <= WAIT_LD;
            busy_q      <= 1'b1;
            req_read_q  <= ~bus.is_write;
            req_write_q <= bus.is_write;
            addr_bus_q  <= bus.addr;
            dout_q      <= bus.wdata[7:0];
            state_q     <= LO;
          end
        end

        LO: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // A byte read clears the upper half; a word read fills it in HI.
            if (!is_write_q) begin
              rdata_q <= is_word_q ? {rdata_q[15:8], data_bus} : {8'h00, data_bus};
            end
            if (is_word_q) begin
              cnt_q      <= WAIT_LD;
              addr_bus_q <= addr_q + 16'd1;
              dout_q     <= wdata_q[15:8];
              state_q    <= HI;
            end else begin
              req_read_q  <= 1'b0;
              req_write_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end

        HI: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!is_write_q) begin
              rdata_q[15:8] <= data_bus;
            end
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_bus      = req_write_q ? dout_q : 8'bz;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.req_read  = req_read_q;
  assign bus.req_write = req_write_q;
  assign bus.addr_bus  = addr_bus_q;

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  mem_bus_master_if bus0();
  mem_bus_master_if bus1();
  wire [7:0] dbus0;
  wire [7:0] dbus1;

  mem_bus_master #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.master), .data_bus(dbus0)
  );
  mem_bus_master #(.WAIT_STATES(2)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master), .data_bus(dbus1)
  );

  // Memory responders: combinational read data, write on the edge ending a
  // strobed cycle; a reset on that edge aborts the bus cycle.
  logic [7:0] mem0 [0:65535];
  logic [7:0] mem1 [0:65535];
  assign dbus0 = bus0.req_read ? mem0[bus0.addr_bus] : 8'bz;
  assign dbus1 = bus1.req_read ? mem1[bus1.addr_bus] : 8'bz;
  always @(posedge clk) if (reset && bus0.req_write) mem0[bus0.addr_bus] <= dbus0;
  always @(posedge clk) if (reset && bus1.req_write) mem1[bus1.addr_bus] <= dbus1;

  // Monitor view of the selected DUT
  logic        sel;
  wire         m_rr    = sel ? bus1.req_read  : bus0.req_read;
  wire         m_rw    = sel ? bus1.req_write : bus0.req_write;
  wire         m_done  = sel ? bus1.done      : bus0.done;
  wire         m_busy  = sel ? bus1.busy      : bus0.busy;
  wire  [15:0] m_addr  = sel ? bus1.addr_bus  : bus0.addr_bus;
  wire  [15:0] m_rdata = sel ? bus1.rdata     : bus0.rdata;
  wire  [7:0]  m_data  = sel ? dbus1          : dbus0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [15:0] tr_addr [0:63];
  logic [7:0]  tr_data [0:63];

  task automatic drive(input logic s, input logic st, input logic wr, input logic word,
                       input logic [15:0] a, input logic [15:0] wd);
    if (s) begin
      bus1.start = st; bus1.is_write = wr; bus1.is_word = word; bus1.addr = a; bus1.wdata = wd;
    end else begin
      bus0.start = st; bus0.is_write = wr; bus0.is_word = word; bus0.addr = a; bus0.wdata = wd;
    end
  endtask

  // One transaction; cycle k = k-th cycle after the accepting edge.
  task automatic run_txn(input logic s, input logic wr, input logic word,
                         input logic [15:0] a, input logic [15:0] wd,
                         output int done_cyc, output int act, output int ovl);
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, wr, word, a, wd);
    @(posedge clk);
    #1;
    // Scramble inputs: the captured request must be unaffected.
    drive(s, 1'b0, ~wr, ~word, ~a, ~wd);
    done_cyc = 0; act = 0; ovl = 0;
    for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (m_rr || m_rw) begin
        tr_addr[act] = m_addr;
        tr_data[act] = m_data;
        act++;
      end
      if (m_rr && m_rw) ovl++;
      if (m_done) done_cyc = k;
    end
  endtask

  typedef struct {
    logic        wr;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_done;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
    logic [7:0]  exp_d0;
    logic [7:0]  exp_d1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dc, ac, ov, dones, d1, d2;
    logic b4, b5;
    logic [15:0] a5, r1, r2;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h00AB, 2, 16'h1234, 16'h0000, 8'hAB, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 16'hC000, 16'hBEEF, 16'h00AB, 3, 16'hC000, 16'hC001, 8'hEF, 8'hBE};
    vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234, 3, 16'hFFFF, 16'h0000, 8'h34, 8'h12};
    vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h77C3, 16'h1234, 2, 16'h0010, 16'h0000, 8'hC3, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00C3, 2, 16'h0010, 16'h0000, 8'hC3, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h5EC3, 3, 16'h0010, 16'h0011, 8'hC3, 8'h5E};

    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[16'h1234] = 8'hAB;
    mem0[16'hFFFF] = 8'h34;
    mem0[16'h0000] = 8'h12;
    mem0[16'h0011] = 8'h5E;
    mem0[16'hD001] = 8'h66;
    mem1[16'h8000] = 8'h5A;
    mem1[16'h8001] = 8'hC1;

    sel = 1'b0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy0",  bus0.busy, 0);
    chk("rst_done0",  bus0.done, 0);
    chk("rst_rdata0", bus0.rdata, 0);
    chk("rst_rr0",    bus0.req_read, 0);
    chk("rst_rw0",    bus0.req_write, 0);
    chk("rst_addr0",  bus0.addr_bus, 0);
    chk("rst_busy1",  bus1.busy, 0);
    chk("rst_addr1",  bus1.addr_bus, 0);
    reset = 1'b1;

    // Table-driven transactions, W=0
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b0, vecs[i].wr, vecs[i].word, vecs[i].addr, vecs[i].wdata, dc, ac, ov);
      chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
      chk($sformatf("v%0d_rdata", i), m_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_busy_at_done", i), m_busy, 0);
      chk($sformatf("v%0d_active_cycles", i), ac, vecs[i].word ? 2 : 1);
      chk($sformatf("v%0d_strobe_overlap", i), ov, 0);
      chk($sformatf("v%0d_addr0", i), tr_addr[0], vecs[i].exp_a0);
      chk($sformatf("v%0d_data0", i), tr_data[0], vecs[i].exp_d0);
      if (vecs[i].word) begin
        chk($sformatf("v%0d_addr1", i), tr_addr[1], vecs[i].exp_a1);
        chk($sformatf("v%0d_data1", i), tr_data[1], vecs[i].exp_d1);
      end
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_mem_lo", i), mem0[vecs[i].addr], vecs[i].wdata[7:0]);
        if (vecs[i].word)
          chk($sformatf("v%0d_mem_hi", i), mem0[vecs[i].addr + 16'd1], vecs[i].wdata[15:8]);
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), m_done, 0);
      chk($sformatf("v%0d_addr_hold", i), m_addr, vecs[i].word ? vecs[i].exp_a1 : vecs[i].exp_a0);
    end

    // Wait states (W=2): byte read then word read
    run_txn(1'b1, 1'b0, 1'b0, 16'h8000, 16'h0000, dc, ac, ov);
    chk("ws_byte_done_cycle", dc, 4);
    chk("ws_byte_active", ac, 3);
    chk("ws_byte_rdata", m_rdata, 16'h005A);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws_byte_addr%0d", k), tr_addr[k], 16'h8000);
      chk($sformatf("ws_byte_data%0d", k), tr_data[k], 8'h5A);
    end
    @(negedge clk);
    run_txn(1'b1, 1'b0, 1'b1, 16'h8000, 16'h0000, dc, ac, ov);
    chk("ws_word_done_cycle", dc, 7);
    chk("ws_word_active", ac, 6);
    chk("ws_word_rdata", m_rdata, 16'hC15A);
    for (int k = 0; k < 6; k++)
      chk($sformatf("ws_word_addr%0d", k), tr_addr[k], (k < 3) ? 16'h8000 : 16'h8001);

    // start held high during a word read; inputs change after acceptance
    sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    @(posedge clk);
    #1;
    bus0.addr = 16'h1234;
    bus0.is_word = 1'b0;
    dones = 0; d1 = 0; d2 = 0; b4 = 1'b1; b5 = 1'b0; a5 = 16'h0; r1 = 16'h0; r2 = 16'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m_done) begin
        dones++;
        if (dones == 1) begin d1 = k; r1 = m_rdata; end
        else begin d2 = k; r2 = m_rdata; end
      end
      if (k == 4) b4 = m_busy;
      if (k == 5) begin
        b5 = m_busy;
        a5 = m_addr;
        bus0.start = 1'b0;
      end
    end
    chk("spam_done_count", dones, 2);
    chk("spam_first_done", d1, 3);
    chk("spam_second_done", d2, 6);
    chk("spam_idle_busy", b4, 0);
    chk("spam_accept_busy", b5, 1);
    chk("spam_second_addr", a5, 16'h1234);
    chk("spam_first_rdata", r1, 16'h1234);
    chk("spam_second_rdata", r2, 16'h00AB);

    // Reset asserted during the HI cycle of a word write
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hD000, 16'h9955);
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    @(negedge clk);
    chk("rst_mid_lo_rw", m_rw, 1);
    chk("rst_mid_lo_addr", m_addr, 16'hD000);
    @(negedge clk);
    chk("rst_mid_hi_rw", m_rw, 1);
    chk("rst_mid_hi_addr", m_addr, 16'hD001);
    chk("rst_mid_hi_data", m_data, 8'h99);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_rw", m_rw, 0);
    chk("rst_mid_rr", m_rr, 0);
    chk("rst_mid_busy", m_busy, 0);
    chk("rst_mid_done", m_done, 0);
    chk("rst_mid_rdata", m_rdata, 16'h0000);
    chk("rst_mid_addr", m_addr, 16'h0000);
    chk("rst_mid_mem_hi", mem0[16'hD001], 8'h66);
    chk("rst_mid_mem_lo", mem0[16'hD000], 8'h55);
    @(negedge clk);
    chk("rst_mid_no_done", m_done, 0);
    reset = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 1'b0, 1'b0, 16'hD000, 16'h0000, dc, ac, ov);
    chk("post_rst_done_cycle", dc, 2);
    chk("post_rst_rdata", m_rdata, 16'h0055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the shared memory bus (req_read, req_write, addr_bus, tri-state data_bus).
- Converts single-cycle CPU access requests (byte or 16-bit word) into one or two sequential byte bus cycles.
- Word accesses are little-endian.
- Captures read data and reports completion with a one-cycle done pulse; sits between the CPU core and the memory responder.

Parameters:
- WAIT_STATES, 0: extra cycles each byte bus cycle is held beyond the first; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- start  input  1  request strobe from CPU; sampled only in IDLE
- is_write  input  1  1 = write, 0 = read; captured with start
- is_word  input  1  1 = 16-bit access, 0 = byte access; captured with start
- addr  input  16  access base address; captured with start
- wdata  input  16  write data; the byte access uses [7:0]; captured with start
- busy  output  1  high from the cycle after start is accepted until done is asserted
- done  output  1  one-cycle completion pulse
- rdata  output  16  read result, valid from done onward until the next accepted read
- req_read  output  1  bus read strobe
- req_write  output  1  bus write strobe
- addr_bus  output  16  bus address
- data_bus  inout  8  bus data; driven only while req_write=1, otherwise 'z

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low.
- Reset values (while reset=0, regardless of state): busy=0, done=0, rdata=16'h0000, req_read=0, req_write=0, addr_bus=16'h0000, data_bus='z; state=IDLE.
  - Reset mid-transaction aborts it with no done pulse. A write byte already strobed may have committed.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - On start=1, capture is_write/is_word/addr/wdata, load wait counter = WAIT_STATES, and go to LO.
  - Otherwise stay. All bus outputs are inactive.
- LO (low-byte cycle):
  - addr_bus = captured addr.
  - Read: req_read=1.
  - Write: req_write=1, data_bus = wdata[7:0].
  - Held while the wait counter > 0; the counter decrements each cycle.
  - On the last cycle (counter = 0):
    - Read: sample data_bus into rdata[7:0].
    - Word access: reload the counter and go to HI. Byte access: go to DONE.
- HI (high-byte cycle):
  - addr_bus = captured addr + 1, mod 2^16 (0xFFFF wraps to 0x0000).
  - Data lane is wdata[15:8] / rdata[15:8]. Same hold and sampling rules as LO, then go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, all bus strobes 0, then IDLE.
  - start is ignored in DONE; it is accepted only in IDLE.
- Byte read: rdata[15:8] is cleared to 0 at the LO sample.
- Write: rdata is unchanged.
- req_read and req_write are never high in the same cycle.
- addr_bus holds its last value when idle.
- start while busy or done is ignored (no queueing). is_write/is_word/addr/wdata changes after acceptance have no effect.
- Latency with W = WAIT_STATES, start accepted at edge T:
  - Byte access: bus active for W+1 cycles, done in cycle T+W+2.
  - Word access: bus active for 2(W+1) cycles, done in cycle T+2W+3.
- Back-to-back: the next start is accepted in the IDLE cycle following DONE.
  - Minimum spacing, W=0: 3 cycles per byte access, 4 per word access.

Test Plan:
- W=0, reset held low 2 cycles, then memory[0x1234]=0xAB; byte read 0x1234 -> req_read high exactly 1 cycle with addr_bus=0x1234; done pulse 2 cycles after start edge; rdata=0x00AB.
- W=0, word write addr=0xC000, wdata=0xBEEF -> cycle 1: req_write, addr_bus=0xC000, data_bus=0xEF; cycle 2: addr_bus=0xC001, data_bus=0xBE; memory then holds EF,BE; data_bus 'z otherwise.
- W=0, word read at 0xFFFF with mem[0xFFFF]=0x34, mem[0x0000]=0x12 -> addr_bus 0xFFFF then 0x0000; rdata=0x1234.
- WAIT_STATES=2, byte read 0x8000 (mem=0x5A) -> req_read held 3 cycles, addr_bus stable; done at T+4; rdata=0x005A.
- start pulsed every cycle during a word read -> exactly one transaction, one done pulse; next start accepted only in the cycle after done.
- reset driven low during HI of a word write to 0xD000 -> next edge: all strobes 0, data_bus 'z, busy=0, rdata=0, no done; mem[0xD001] unchanged.
